// File: rtl/mult32_pkg.sv
// Shared types and constants for the 32-bit sequential shift-add multiplier.
package mult32_pkg;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned ITER_LAST = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder32.sv
// 32-bit adder with carry in/out used for the partial-product accumulate step.
module full_adder32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  logic [32:0] total;

  always_comb begin
    total  = {1'b0, a_i} + {1'b0, b_i} + {32'd0, cin_i};
    sum_o  = total[31:0];
    cout_o = total[32];
  end

endmodule

// File: rtl/mult32_seq.sv
// Sequential 32x32->64 unsigned shift-add multiplier, one iteration per clock.
// Optional overflow flag output enabled by defining MULT32_SEQ_OVF_EN.
module mult32_seq
  import mult32_pkg::*;
#(
  parameter int unsigned WIDTH = mult32_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic             busy
`ifdef MULT32_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CW-1:0]    count_q, count_d;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             carry;

  assign addend = lo_q[0] ? mcand_q : '0;

  full_adder32 u_add (
    .a_i    (hi_q),
    .b_i    (addend),
    .cin_i  (1'b0),
    .sum_o  (sum),
    .cout_o (carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mcand_d   = mcand_q;
    count_d   = count_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          hi_d    = '0;
          lo_d    = b;
          mcand_d = a;
          count_d = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy    = 1'b1;
        // Carry becomes the new MSB of hi; sum[0] shifts into the top of lo.
        hi_d    = {carry, sum[WIDTH-1:1]};
        lo_d    = {sum[0], lo_q[WIDTH-1:1]};
        count_d = count_q + 1'b1;
        if (count_q == CW'(ITER_LAST)) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign product = {hi_q, lo_q};

`ifdef MULT32_SEQ_OVF_EN
  assign ovf = (state_q == DONE) && (hi_q != '0);
`endif

endmodule

// File: tb/tb_mult32_seq.sv
// Directed self-checking bench for mult32_seq; builds with or without MULT32_SEQ_OVF_EN.
module tb_mult32_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
  logic        busy;
`ifdef MULT32_SEQ_OVF_EN
  logic        ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  mult32_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
`ifdef MULT32_SEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the accept edge.
  task automatic accept(input string tag, input logic [31:0] av, input logic [31:0] bv);
    a = av;
    b = bv;
    in_valid = 1'b1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (!out_valid && n < 64) begin
      step();
      n++;
    end
    check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_idle_nvalid"}, 64'(out_valid), 64'd0);
  endtask

  task automatic run(input string tag, input logic [31:0] av, input logic [31:0] bv,
                     input logic [63:0] exp, input logic exp_ovf);
    int n;
    accept(tag, av, bv);
    wait_done(tag, n);
    check({tag, "_latency"}, 64'(n), 64'd32);
    check({tag, "_product"}, product, exp);
    check({tag, "_no_ready"}, 64'(in_ready), 64'd0);
`ifdef MULT32_SEQ_OVF_EN
    check({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("unused");
`endif
    release_out(tag);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    @(negedge clk);
    step();
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_product", product, 64'd0);
`ifdef MULT32_SEQ_OVF_EN
    check("rst_ovf", 64'(ovf), 64'd0);
`endif

    run("basic", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0);
    run("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
    run("zero", 32'd0, 32'h1234_5678, 64'd0, 1'b0);
    run("ident", 32'h1234_5678, 32'd1, 64'h0000_0000_1234_5678, 1'b0);

    // Backpressure with a competing request pending throughout DONE.
    accept("bp", 32'h0001_0000, 32'h0001_0000);
    wait_done("bp", n);
    a = 32'd9;
    b = 32'd11;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_hold_product", product, 64'h0000_0001_0000_0000);
      check("bp_hold_in_ready", 64'(in_ready), 64'd0);
      check("bp_hold_out_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_busy", 64'(busy), 64'd0);
    step();
    in_valid = 1'b0;
    check("bp_next_busy", 64'(busy), 64'd1);
    wait_done("bp_next", n);
    check("bp_next_latency", 64'(n), 64'd32);
    check("bp_next_product", product, 64'd99);
    release_out("bp_next");

    // Operand and in_valid activity during BUSY must not disturb the result.
    accept("chg", 32'hDEAD_BEEF, 32'h0000_0010);
    repeat (5) step();
    a = 32'd1;
    b = 32'd1;
    in_valid = 1'b1;
    repeat (3) step();
    check("chg_mid_busy", 64'(busy), 64'd1);
    check("chg_mid_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    wait_done("chg", n);
    check("chg_latency", 64'(n + 8), 64'd32);
    check("chg_product", product, 64'h0000_000D_EADB_EEF0);
    release_out("chg");

    // Abort mid-operation.
    accept("abort", 32'd1000, 32'd1000);
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_product", product, 64'd0);
    run("post_abort", 32'd7, 32'd6, 64'd42, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mult32_seq.md
MULT32_SEQ -- requirements
Module: mult32_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; only 32 is legal.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operand pair a/b is valid.
REQ-005 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have port a  input  32  unsigned multiplicand.
REQ-007 SHALL have port b  input  32  unsigned multiplier.
REQ-008 SHALL have port out_valid  output  1  product is valid.
REQ-009 SHALL have port out_ready  input  1  consumer takes product this cycle.
REQ-010 SHALL have port product  output  64  unsigned a*b.
REQ-011 SHALL have port busy  output  1  iteration in progress.

Function
REQ-012 SHALL implement a three-state FSM IDLE, BUSY, DONE; in_ready=1 only in IDLE; busy=1 only in BUSY; out_valid=1 only in DONE.
REQ-013 SHALL accept on an edge with in_valid&&in_ready: hi[31:0]=0, lo[31:0]=b, mcand=a, count=0, state->BUSY.
REQ-014 SHALL, on each BUSY edge: sum=hi+(lo[0]?mcand:0) with carry c; {hi,lo}={c,sum,lo[31:1]}; count++.
REQ-015 SHALL move BUSY->DONE on the edge where count==31, i.e. after exactly 32 iterations; out_valid is first high 32 cycles after the accept edge.
REQ-016 SHALL drive product={hi,lo}, held stable throughout DONE.
REQ-017 SHALL move DONE->IDLE on an edge with out_ready=1; out_valid and in_ready SHALL never be high in the same cycle.
REQ-018 SHALL ignore in_valid, a and b outside IDLE; operands are captured only at acceptance.
REQ-019 SHALL hold DONE indefinitely while out_ready=0.
REQ-020 SHALL treat arithmetic as unsigned modulo 2^64; the carry out of the 32-bit add is never lost.

Reset
REQ-021 SHALL, on an edge with rst=1, set state=IDLE, hi=lo=mcand=0, count=0; outputs then read in_ready=1, busy=0, out_valid=0, product=0.
REQ-022 SHALL give rst priority over every handshake; rst in BUSY or DONE aborts the operation, and the result is never presented.

Configuration
REQ-023 SHALL, with MULT32_SEQ_OVF_EN defined, add port ovf  output  1, equal to (product[63:32]!=0) while out_valid=1, and 0 otherwise including after reset.
REQ-024 SHALL, without MULT32_SEQ_OVF_EN, omit port ovf and its logic entirely.

Structure
REQ-025 SHALL place the state enum type (IDLE/BUSY/DONE) and the constants WIDTH=32 and ITER_LAST=31 in shared package mult32_pkg.
REQ-026 SHALL instantiate exactly one sub-module, full_adder32 (existing 32-bit ripple adder, carry-in 0), for the hi+addend step; its cout is the carry c.

Verification
REQ-027 SHALL cover basic multiply: a=3, b=5, out_ready=1 -> product=0x0000_0000_0000_000F exactly 32 cycles after accept, with ovf=0 when MULT32_SEQ_OVF_EN is defined.
REQ-028 SHALL cover the maximum operands: a=b=0xFFFF_FFFF -> product=0xFFFF_FFFE_0000_0001, with ovf=1 when MULT32_SEQ_OVF_EN is defined.
REQ-029 SHALL cover zero and identity: a=0, b=0x1234_5678 -> product=0; then a=0x1234_5678, b=1 -> product=0x0000_0000_1234_5678.
REQ-030 SHALL cover backpressure: out_ready=0 for 10 cycles after out_valid -> product stable and in_ready=0 throughout; a new in_valid is not accepted until the edge after out_ready=1.
REQ-031 SHALL cover operand changes during BUSY: change a/b and pulse in_valid mid-BUSY -> result equals the product of the captured operands.
REQ-032 SHALL cover mid-operation reset: rst=1 at iteration 10 -> next cycle in_ready=1, busy=0, out_valid=0, product=0; a following a=7, b=6 -> product=42.
